// File: rtl/pipe_msgbus_phy_responder.sv
// pipe_msgbus_phy_responder
// PHY-side end of the PIPE message bus. Decodes MAC-issued M2P transactions
// (write_uncommitted, write_committed, read) against a local 8-bit register
// file and returns write_ack / read_completion responses on P2M.
//
// Ports:
//   PCLK            PIPE clock, all logic on the rising edge
//   Reset           asynchronous active-low reset, clears all state
//   M2P_MessageBus  MAC->PHY message bytes
//   P2M_MessageBus  PHY->MAC message bytes (8'h00 when idle)
//   reg_file_o      flattened register contents, reg k at [8k+7:8k]
//   reg_update_o    1-cycle pulse when a commit has updated the registers
//   error_o         1-cycle pulse on illegal command or buffer/queue overflow
module pipe_msgbus_phy_responder #(
  parameter int NUM_REGS       = 16,
  parameter int UNCOMMIT_DEPTH = 4,
  parameter int RESP_DEPTH     = 2
) (
  input  logic                  PCLK,
  input  logic                  Reset,
  input  logic [7:0]            M2P_MessageBus,
  output logic [7:0]            P2M_MessageBus,
  output logic [8*NUM_REGS-1:0] reg_file_o,
  output logic                  reg_update_o,
  output logic                  error_o
);

  localparam int AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int UCW = $clog2(UNCOMMIT_DEPTH + 1);
  localparam int UIW = (UNCOMMIT_DEPTH > 1) ? $clog2(UNCOMMIT_DEPTH) : 1;
  localparam int QCW = $clog2(RESP_DEPTH + 1);
  localparam int QIW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [11:0] MAP_LIMIT = 12'(NUM_REGS);

  typedef enum logic [1:0] {RX_IDLE, RX_ADDR_LO, RX_DATA} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_ACK, TX_HDR, TX_DATA} tx_state_t;
  typedef enum logic [1:0] {K_UNC, K_COM, K_RD} kind_t;

  rx_state_t  rx_state;
  kind_t      kind;
  logic [3:0] addr_hi;
  logic [7:0] addr_lo;

  logic [7:0] regs      [NUM_REGS];
  logic [7:0] next_regs [NUM_REGS];

  logic [11:0]    ub_addr [UNCOMMIT_DEPTH];
  logic [7:0]     ub_data [UNCOMMIT_DEPTH];
  logic [UCW-1:0] ub_count;

  logic           q_rd   [RESP_DEPTH];
  logic [7:0]     q_data [RESP_DEPTH];
  logic [QCW-1:0] q_count;

  tx_state_t  tx_state;
  logic [7:0] tx_data;

  logic [3:0]     cmd;
  logic [11:0]    wr_addr, rd_addr;
  logic           wr_unc_done, wr_com_done, rd_done, illegal;
  logic           ub_overflow, q_overflow;
  logic [7:0]     rd_value;
  logic           new_valid, tx_free, pop, bypass, push, push_ok;
  logic           start_rd;
  logic [7:0]     start_data;
  logic [QIW-1:0] q_slot;
  logic [UIW-1:0] ub_slot;

  // Decode the current byte against the RX state and work out which
  // response (if any) the TX side starts this cycle. A response bypasses
  // the queue when the transmitter is free and nothing is waiting.
  always_comb begin
    cmd         = M2P_MessageBus[7:4];
    wr_addr     = {addr_hi, addr_lo};
    rd_addr     = {addr_hi, M2P_MessageBus};
    wr_unc_done = (rx_state == RX_DATA) && (kind == K_UNC);
    wr_com_done = (rx_state == RX_DATA) && (kind == K_COM);
    rd_done     = (rx_state == RX_ADDR_LO) && (kind == K_RD);
    illegal     = (rx_state == RX_IDLE) && (cmd >= 4'h4);
    ub_overflow = wr_unc_done && (ub_count == UCW'(UNCOMMIT_DEPTH));
    rd_value    = (rd_addr < MAP_LIMIT) ? regs[rd_addr[AW-1:0]] : 8'h00;
    new_valid   = wr_com_done || rd_done;
    tx_free     = (tx_state != TX_HDR);
    pop         = tx_free && (q_count != '0);
    bypass      = tx_free && (q_count == '0) && new_valid;
    push        = new_valid && !bypass;
    q_overflow  = push && (q_count == QCW'(RESP_DEPTH)) && !pop;
    push_ok     = push && !q_overflow;
    start_rd    = pop ? q_rd[0] : rd_done;
    start_data  = pop ? q_data[0] : rd_value;
    q_slot      = QIW'(pop ? (q_count - QCW'(1)) : q_count);
    ub_slot     = UIW'(ub_count);
  end

  // Commit image: buffered entries in arrival order, then the committed
  // write itself, so a later write to the same address wins. Unmapped
  // addresses are simply skipped.
  always_comb begin
    next_regs = regs;
    if (wr_com_done) begin
      for (int i = 0; i < UNCOMMIT_DEPTH; i++) begin
        if ((UCW'(i) < ub_count) && (ub_addr[i] < MAP_LIMIT))
          next_regs[ub_addr[i][AW-1:0]] = ub_data[i];
      end
      if (wr_addr < MAP_LIMIT)
        next_regs[wr_addr[AW-1:0]] = M2P_MessageBus;
    end
  end

  always_comb begin
    reg_file_o = '0;
    for (int k = 0; k < NUM_REGS; k++)
      reg_file_o[8*k +: 8] = regs[k];
  end

  // RX and TX state machines, register file, uncommitted buffer and
  // response queue. All outputs are registered here.
  always_ff @(posedge PCLK or negedge Reset) begin
    if (!Reset) begin
      rx_state       <= RX_IDLE;
      kind           <= K_UNC;
      addr_hi        <= '0;
      addr_lo        <= '0;
      ub_count       <= '0;
      q_count        <= '0;
      tx_state       <= TX_IDLE;
      tx_data        <= '0;
      P2M_MessageBus <= 8'h00;
      reg_update_o   <= 1'b0;
      error_o        <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      for (int i = 0; i < UNCOMMIT_DEPTH; i++) begin
        ub_addr[i] <= '0;
        ub_data[i] <= '0;
      end
      for (int i = 0; i < RESP_DEPTH; i++) begin
        q_rd[i]   <= 1'b0;
        q_data[i] <= '0;
      end
    end else begin
      case (rx_state)
        RX_IDLE: begin
          addr_hi <= M2P_MessageBus[3:0];
          case (cmd)
            4'h1: begin kind <= K_UNC; rx_state <= RX_ADDR_LO; end
            4'h2: begin kind <= K_COM; rx_state <= RX_ADDR_LO; end
            4'h3: begin kind <= K_RD;  rx_state <= RX_ADDR_LO; end
            default: rx_state <= RX_IDLE;
          endcase
        end
        RX_ADDR_LO: begin
          addr_lo  <= M2P_MessageBus;
          rx_state <= (kind == K_RD) ? RX_IDLE : RX_DATA;
        end
        default: rx_state <= RX_IDLE;
      endcase

      error_o      <= illegal || ub_overflow || q_overflow;
      reg_update_o <= wr_com_done;

      if (wr_com_done) begin
        regs     <= next_regs;
        ub_count <= '0;
      end else if (wr_unc_done && !ub_overflow) begin
        ub_addr[ub_slot] <= wr_addr;
        ub_data[ub_slot] <= M2P_MessageBus;
        ub_count         <= ub_count + UCW'(1);
      end

      if (pop) begin
        for (int i = 0; i < RESP_DEPTH - 1; i++) begin
          q_rd[i]   <= q_rd[i+1];
          q_data[i] <= q_data[i+1];
        end
      end
      if (push_ok) begin
        q_rd[q_slot]   <= rd_done;
        q_data[q_slot] <= rd_value;
      end
      case ({push_ok, pop})
        2'b10:   q_count <= q_count + QCW'(1);
        2'b01:   q_count <= q_count - QCW'(1);
        default: q_count <= q_count;
      endcase

      // A read completion holds the transmitter for two cycles (header,
      // data); every other state ends this cycle and can start the next one.
      if (tx_state == TX_HDR) begin
        P2M_MessageBus <= tx_data;
        tx_state       <= TX_DATA;
      end else if (pop || bypass) begin
        if (start_rd) begin
          P2M_MessageBus <= 8'h40;
          tx_data        <= start_data;
          tx_state       <= TX_HDR;
        end else begin
          P2M_MessageBus <= 8'h50;
          tx_state       <= TX_ACK;
        end
      end else begin
        P2M_MessageBus <= 8'h00;
        tx_state       <= TX_IDLE;
      end
    end
  end

endmodule
